sample_frame_decimator: RTL and testbench

- Reader end of the filter output stream. Takes the per-strobe sample stream leaving the decimation low-pass IIR cascade and decimates it by 2^LOG2_DECIM.
- Packs decimated samples into frames of 2^LOG2_FRAME words in an internal buffer.
- Hands each complete frame to the FFT front end over a valid/ready stream with a last flag.
- While a frame is draining, new input samples are dropped and counted.

---
 rtl/sample_frame_decimator_if.sv | 13 +
 rtl/sample_frame_decimator.sv | 144 ++++++++++++++
 tb/tb_sample_frame_decimator.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sample_frame_decimator_if.sv
// Frame output stream from the sample frame decimator to the FFT front end.
// The master drives data/valid/last; the slave drives ready.
interface sample_frame_decimator_if #(
    parameter int WORD_SIZE = 18
);
    logic [WORD_SIZE-1:0] outData;
    logic                 outValid;
    logic                 outReady;
    logic                 outLast;

    modport master (output outData, output outValid, output outLast, input outReady);
    modport slave  (input outData, input outValid, input outLast, output outReady);
endinterface

// File: rtl/sample_frame_decimator.sv
// Decimates the filter output by 2^LOG2_DECIM, packs frames of 2^LOG2_FRAME words and drains them.
// Define SAMPLE_FRAME_DECIMATOR_AVERAGE_EN for block-average decimation; the default build picks phase 0.
module sample_frame_decimator #(
    parameter int WORD_SIZE  = 18,
    parameter int LOG2_DECIM = 2,
    parameter int LOG2_FRAME = 8
) (
    input  logic                        inClock,
    input  logic                        reset,
    input  logic signed [WORD_SIZE-1:0] inData,
    input  logic                        inStrobe,
    sample_frame_decimator_if.master    out_if,
    output logic                        frameReady,
    output logic [7:0]                  dropCount
);
    localparam int DEPTH   = 1 << LOG2_FRAME;
    localparam int PHASE_W = (LOG2_DECIM > 0) ? LOG2_DECIM : 1;
    localparam logic [PHASE_W-1:0]    PHASE_LAST = PHASE_W'((1 << LOG2_DECIM) - 1);
    localparam logic [LOG2_FRAME-1:0] IDX_LAST   = LOG2_FRAME'(DEPTH - 1);

    typedef enum logic {FILL, DRAIN} state_e;

    state_e                 state_q, state_d;
    logic [PHASE_W-1:0]     phase_q, phase_d;
    logic [LOG2_FRAME-1:0]  wr_idx_q, wr_idx_d;
    logic [LOG2_FRAME-1:0]  rd_idx_q, rd_idx_d;
    logic [WORD_SIZE-1:0]   out_data_q, out_data_d;
    logic                   out_valid_q, out_valid_d;
    logic                   out_last_q, out_last_d;
    logic [7:0]             drop_count_q, drop_count_d;
    logic                   wr_en;
    logic [WORD_SIZE-1:0]   wr_data;
    logic [WORD_SIZE-1:0]   mem [DEPTH];

`ifdef SAMPLE_FRAME_DECIMATOR_AVERAGE_EN
    // One guard bit per halving keeps the group sum from ever overflowing.
    localparam int ACC_W = WORD_SIZE + LOG2_DECIM;
    logic signed [ACC_W-1:0] acc_q, acc_d, acc_sum;
`endif

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d      = state_q;
        phase_d      = phase_q;
        wr_idx_d     = wr_idx_q;
        rd_idx_d     = rd_idx_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        drop_count_d = drop_count_q;
        wr_en        = 1'b0;
        wr_data      = inData;
`ifdef SAMPLE_FRAME_DECIMATOR_AVERAGE_EN
        acc_sum = acc_q + ACC_W'(inData);
        acc_d   = acc_q;
`endif
        case (state_q)
            FILL: begin
                if (inStrobe) begin
                    phase_d = (phase_q == PHASE_LAST) ? '0 : phase_q + 1'b1;
`ifdef SAMPLE_FRAME_DECIMATOR_AVERAGE_EN
                    if (phase_q == PHASE_LAST) begin
                        wr_en   = 1'b1;
                        wr_data = WORD_SIZE'(acc_sum >>> LOG2_DECIM);
                        acc_d   = '0;
                    end else begin
                        acc_d = acc_sum;
                    end
`else
                    wr_en = (phase_q == '0);
`endif
                    if (wr_en) begin
                        wr_idx_d = wr_idx_q + 1'b1;
                        if (wr_idx_q == IDX_LAST) begin
                            state_d  = DRAIN;
                            wr_idx_d = '0;
                            phase_d  = '0;
                            rd_idx_d = '0;
                        end
                    end
                end
            end
            DRAIN: begin
                if (inStrobe && drop_count_q != 8'hFF) drop_count_d = drop_count_q + 8'd1;
                if (out_valid_q && out_if.outReady && out_last_q) begin
                    state_d     = FILL;
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
`ifdef SAMPLE_FRAME_DECIMATOR_AVERAGE_EN
                    acc_d = '0;
`endif
                end else if (!out_valid_q || out_if.outReady) begin
                    // Output register is empty or being emptied: refill it from the buffer.
                    out_data_d  = mem[rd_idx_q];
                    out_valid_d = 1'b1;
                    out_last_d  = (rd_idx_q == IDX_LAST);
                    rd_idx_d    = rd_idx_q + 1'b1;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge inClock or negedge reset) begin
        if (!reset) begin
            state_q      <= FILL;
            phase_q      <= '0;
            wr_idx_q     <= '0;
            rd_idx_q     <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            drop_count_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q      <= state_d;
            phase_q      <= phase_d;
            wr_idx_q     <= wr_idx_d;
            rd_idx_q     <= rd_idx_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            drop_count_q <= drop_count_d;
        end
    end

`ifdef SAMPLE_FRAME_DECIMATOR_AVERAGE_EN
    always_ff @(posedge inClock or negedge reset) begin
        if (!reset) acc_q <= '0;
        else        acc_q <= acc_d;
    end
`endif

    // NOTE: the buffer has no reset; resetting the indices is enough to discard a partial frame.
    always_ff @(posedge inClock) begin
        if (wr_en) mem[wr_idx_q] <= wr_data;
    end

    assign out_if.outData  = out_data_q;
    assign out_if.outValid = out_valid_q;
    assign out_if.outLast  = out_last_q;
    assign frameReady      = (state_q == DRAIN);
    assign dropCount       = drop_count_q;
endmodule

// File: tb/tb_sample_frame_decimator.sv
// Directed bench for sample_frame_decimator (LOG2_DECIM=2, LOG2_FRAME=3, plus a LOG2_DECIM=0 instance).
module tb_sample_frame_decimator;
    localparam int WS = 18;
    localparam int N  = 8;
`ifdef SAMPLE_FRAME_DECIMATOR_AVERAGE_EN
    localparam bit AVG          = 1'b1;
    localparam int FILL_STROBES = 32;
`else
    localparam bit AVG          = 1'b0;
    localparam int FILL_STROBES = 29;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_n;
    logic signed [WS-1:0] in_data, in_data0;
    logic                 in_strobe, in_strobe0;
    logic                 frame_ready, frame_ready0;
    logic [7:0]           drop_count, drop_count0;

    sample_frame_decimator_if #(.WORD_SIZE(WS)) s_if ();
    sample_frame_decimator_if #(.WORD_SIZE(WS)) s0_if ();

    sample_frame_decimator #(.WORD_SIZE(WS), .LOG2_DECIM(2), .LOG2_FRAME(3)) u_dut (
        .inClock(clk), .reset(rst_n), .inData(in_data), .inStrobe(in_strobe),
        .out_if(s_if.master), .frameReady(frame_ready), .dropCount(drop_count)
    );

    sample_frame_decimator #(.WORD_SIZE(WS), .LOG2_DECIM(0), .LOG2_FRAME(3)) u_dut0 (
        .inClock(clk), .reset(rst_n), .inData(in_data0), .inStrobe(in_strobe0),
        .out_if(s0_if.master), .frameReady(frame_ready0), .dropCount(drop_count0)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic fill_frame(input int base, input bit ramp);
        for (int i = 0; i < FILL_STROBES; i++) begin
            in_strobe = 1'b1;
            in_data   = WS'(ramp ? base + i : base + i / 4);
            tick();
        end
        in_strobe = 1'b0;
    endtask

    // Drains with mode 0 (always ready) or mode 1 (ready 1,0,0,1,0,1 repeating); records transfers.
    task automatic drain(input int mode, input int stop_after, input bit strobe_last,
                         output logic [WS-1:0] data [N], output logic last [N],
                         output int n, output int hold_err, output bit timeout);
        logic          pv, pr, pl, r, xfer, xlast;
        logic [WS-1:0] pd;
        n = 0; hold_err = 0; timeout = 1'b1;
        pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0;
        for (int k = 0; k < N; k++) begin
            data[k] = '0;
            last[k] = 1'b0;
        end
        for (int c = 0; c < 200; c++) begin
            r = (mode == 0) ? 1'b1 : ((c % 6) inside {0, 3, 5});
            s_if.outReady = r;
            if (pv && !pr && (s_if.outValid !== 1'b1 || s_if.outData !== pd || s_if.outLast !== pl))
                hold_err++;
            xfer  = (s_if.outValid === 1'b1) && r;
            xlast = xfer && (s_if.outLast === 1'b1);
            in_strobe = strobe_last && xlast;
            if (xfer) begin
                if (n < N) begin
                    data[n] = s_if.outData;
                    last[n] = s_if.outLast;
                end
                n++;
            end
            pv = s_if.outValid; pr = r; pd = s_if.outData; pl = s_if.outLast;
            tick();
            if (xlast || (xfer && n == stop_after)) begin
                timeout = 1'b0;
                break;
            end
        end
        in_strobe = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_strobe = 1'b0; in_data = '0; in_strobe0 = 1'b0; in_data0 = '0;
        s_if.outReady = 1'b0; s0_if.outReady = 1'b0;
        #3;
        n_checks++; if (s_if.outData !== 18'd0) $display("FAIL reset_outData: got %h expected 0", s_if.outData); else n_pass++;
        n_checks++; if (s_if.outValid !== 1'b0) $display("FAIL reset_outValid: got %b expected 0", s_if.outValid); else n_pass++;
        n_checks++; if (s_if.outLast !== 1'b0) $display("FAIL reset_outLast: got %b expected 0", s_if.outLast); else n_pass++;
        n_checks++; if (frame_ready !== 1'b0) $display("FAIL reset_frameReady: got %b expected 0", frame_ready); else n_pass++;
        n_checks++; if (drop_count !== 8'd0) $display("FAIL reset_dropCount: got %0d expected 0", drop_count); else n_pass++;
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_ramp();
        logic [WS-1:0] w [N];
        logic          l [N];
        int            cyc [N];
        logic          fr [48];
        logic          ov [48];
        int            n, lc;
        do_reset();
        s_if.outReady = 1'b1;
        n = 0; lc = -1;
        for (int c = 0; c < 48; c++) begin
            in_strobe = (c < 32);
            in_data   = WS'(c);
            tick();
            fr[c] = frame_ready;
            ov[c] = s_if.outValid;
            if (s_if.outValid === 1'b1) begin
                if (n < N) begin
                    w[n] = s_if.outData; l[n] = s_if.outLast; cyc[n] = c;
                end
                if (s_if.outLast === 1'b1 && lc < 0) lc = c;
                n++;
            end
        end
        in_strobe = 1'b0;
        n_checks++; if (n !== N) $display("FAIL ramp_count: got %0d expected %0d", n, N); else n_pass++;
        for (int k = 0; k < N && k < n; k++) begin
            n_checks++;
            if (w[k] !== WS'(AVG ? 4 * k + 1 : 4 * k) || l[k] !== (k == N - 1))
                $display("FAIL ramp_word%0d: got %0d last %b expected %0d last %b", k, w[k], l[k], AVG ? 4 * k + 1 : 4 * k, k == N - 1);
            else n_pass++;
        end
        if (n >= N) begin
            n_checks++; if (cyc[N-1] - cyc[0] !== N - 1) $display("FAIL ramp_throughput: got span %0d expected %0d", cyc[N-1] - cyc[0], N - 1); else n_pass++;
        end
        n_checks++;
        if (lc < 0 || lc > 46 || fr[lc] !== 1'b1 || fr[lc+1] !== 1'b0 || ov[lc+1] !== 1'b0)
            $display("FAIL ramp_frameReady_fall: last at cycle %0d, frameReady/outValid after not 0/0", lc);
        else n_pass++;
        n_checks++; if (drop_count !== (AVG ? 8'd0 : 8'd3)) $display("FAIL ramp_drops: got %0d expected %0d", drop_count, AVG ? 0 : 3); else n_pass++;
    endtask

    task automatic test_group_values();
        logic [WS-1:0] vals [32];
        logic [WS-1:0] exp_w [N];
        logic [WS-1:0] w [N];
        logic          l [N];
        int            n, he;
        bit            to;
        vals = '{18'd1, 18'd2, 18'd3, 18'd4, 18'h3FFFF, 18'h3FFFE, 18'h3FFFE, 18'h3FFFE,
                 18'h1FFFF, 18'h1FFFF, 18'h1FFFF, 18'h1FFFF, 18'h20000, 18'h20000, 18'h20000, 18'h20000,
                 18'd5, 18'd5, 18'd5, 18'd5, 18'd6, 18'd6, 18'd6, 18'd6,
                 18'd7, 18'd7, 18'd7, 18'd7, 18'd8, 18'd8, 18'd8, 18'd8};
        if (AVG) exp_w = '{18'd2, 18'h3FFFE, 18'h1FFFF, 18'h20000, 18'd5, 18'd6, 18'd7, 18'd8};
        else     exp_w = '{18'd1, 18'h3FFFF, 18'h1FFFF, 18'h20000, 18'd5, 18'd6, 18'd7, 18'd8};
        do_reset();
        s_if.outReady = 1'b0;
        for (int i = 0; i < FILL_STROBES; i++) begin
            in_strobe = 1'b1;
            in_data   = vals[i];
            tick();
        end
        in_strobe = 1'b0;
        drain(0, N, 1'b0, w, l, n, he, to);
        n_checks++; if (n !== N || to) $display("FAIL group_count: got %0d timeout %b expected %0d", n, to, N); else n_pass++;
        for (int k = 0; k < N; k++) begin
            n_checks++;
            if (w[k] !== exp_w[k]) $display("FAIL group_word%0d: got %h expected %h", k, w[k], exp_w[k]);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        logic [WS-1:0] w [N];
        logic          l [N];
        int            n, he;
        bit            to;
        do_reset();
        fill_frame(100, 1'b0);
        drain(1, N, 1'b0, w, l, n, he, to);
        n_checks++; if (to) $display("FAIL bp_timeout: got timeout 1 expected 0"); else n_pass++;
        n_checks++; if (n !== N) $display("FAIL bp_count: got %0d expected %0d", n, N); else n_pass++;
        n_checks++; if (he !== 0) $display("FAIL bp_hold: got %0d changes expected 0", he); else n_pass++;
        for (int k = 0; k < N; k++) begin
            n_checks++;
            if (w[k] !== WS'(100 + k) || l[k] !== (k == N - 1))
                $display("FAIL bp_word%0d: got %0d last %b expected %0d last %b", k, w[k], l[k], 100 + k, k == N - 1);
            else n_pass++;
        end
        n_checks++;
        if (s_if.outValid !== 1'b0 || frame_ready !== 1'b0)
            $display("FAIL bp_end: got valid %b frameReady %b expected 0 0", s_if.outValid, frame_ready);
        else n_pass++;
    endtask

    task automatic test_drops();
        logic [WS-1:0] w [N];
        logic          l [N];
        int            n, he;
        bit            to;
        do_reset();
        fill_frame(200, 1'b0);
        n_checks++; if (drop_count !== 8'd0) $display("FAIL drop_fill: got %0d expected 0", drop_count); else n_pass++;
        s_if.outReady = 1'b0;
        for (int i = 0; i < 300; i++) begin
            in_strobe = 1'b1;
            in_data   = WS'(i);
            tick();
        end
        in_strobe = 1'b0;
        n_checks++; if (drop_count !== 8'd255) $display("FAIL drop_sat: got %0d expected 255", drop_count); else n_pass++;
        n_checks++;
        if (s_if.outValid !== 1'b1 || s_if.outData !== WS'(200) || frame_ready !== 1'b1)
            $display("FAIL drop_hold: got valid %b data %0d fr %b expected 1 200 1", s_if.outValid, s_if.outData, frame_ready);
        else n_pass++;
        drain(0, N, 1'b0, w, l, n, he, to);
        n_checks++; if (n !== N || w[7] !== WS'(207)) $display("FAIL drop_drain: got %0d words last %0d expected 8 207", n, w[7]); else n_pass++;
        n_checks++; if (drop_count !== 8'd255) $display("FAIL drop_stay: got %0d expected 255", drop_count); else n_pass++;

        do_reset();
        fill_frame(600, 1'b0);
        drain(0, N, 1'b1, w, l, n, he, to);
        n_checks++; if (drop_count !== 8'd1) $display("FAIL drop_last_xfer: got %0d expected 1", drop_count); else n_pass++;
        fill_frame(1000, 1'b1);
        drain(0, N, 1'b0, w, l, n, he, to);
        n_checks++; if (n !== N) $display("FAIL phase_count: got %0d expected %0d", n, N); else n_pass++;
        for (int k = 0; k < N; k++) begin
            n_checks++;
            if (w[k] !== WS'(AVG ? 1001 + 4 * k : 1000 + 4 * k))
                $display("FAIL phase_word%0d: got %0d expected %0d", k, w[k], AVG ? 1001 + 4 * k : 1000 + 4 * k);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        logic [WS-1:0] w [N];
        logic          l [N];
        int            n, he;
        bit            to;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            in_strobe = 1'b1;
            in_data   = WS'(50 + i / 4);
            tick();
        end
        in_strobe = 1'b0;
        rst_n = 1'b0;
        #1;
        n_checks++; if (frame_ready !== 1'b0 || s_if.outValid !== 1'b0) $display("FAIL mid_reset_fill: got fr %b valid %b expected 0 0", frame_ready, s_if.outValid); else n_pass++;
        rst_n = 1'b1;
        tick();
        fill_frame(300, 1'b0);
        drain(0, N, 1'b0, w, l, n, he, to);
        n_checks++; if (n !== N) $display("FAIL mid_fill_count: got %0d expected %0d", n, N); else n_pass++;
        for (int k = 0; k < N; k++) begin
            n_checks++;
            if (w[k] !== WS'(300 + k)) $display("FAIL mid_fill_word%0d: got %0d expected %0d", k, w[k], 300 + k);
            else n_pass++;
        end

        fill_frame(400, 1'b0);
        drain(0, 3, 1'b0, w, l, n, he, to);
        n_checks++;
        if (n !== 3 || w[2] !== WS'(402) || s_if.outValid !== 1'b1 || s_if.outData !== WS'(403))
            $display("FAIL mid_drain_pre: got n %0d data %0d expected 3 403", n, s_if.outData);
        else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (s_if.outData !== '0 || s_if.outValid !== 1'b0 || s_if.outLast !== 1'b0 || frame_ready !== 1'b0)
            $display("FAIL mid_drain_reset: got data %0d valid %b last %b fr %b expected all 0",
                     s_if.outData, s_if.outValid, s_if.outLast, frame_ready);
        else n_pass++;
        rst_n = 1'b1;
        tick();
        fill_frame(500, 1'b0);
        drain(0, N, 1'b0, w, l, n, he, to);
        n_checks++; if (n !== N) $display("FAIL mid_after_count: got %0d expected %0d", n, N); else n_pass++;
        for (int k = 0; k < N; k++) begin
            n_checks++;
            if (w[k] !== WS'(500 + k)) $display("FAIL mid_after_word%0d: got %0d expected %0d", k, w[k], 500 + k);
            else n_pass++;
        end
    endtask

    task automatic test_no_decim();
        logic [WS-1:0] w [N];
        logic          l [N];
        int            n;
        bit            done;
        n = 0; done = 1'b0;
        s0_if.outReady = 1'b1;
        for (int i = 0; i < N; i++) begin
            in_strobe0 = 1'b1;
            in_data0   = WS'(7 + i);
            tick();
        end
        in_strobe0 = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            if (s0_if.outValid === 1'b1) begin
                if (n < N) begin
                    w[n] = s0_if.outData; l[n] = s0_if.outLast;
                end
                if (s0_if.outLast === 1'b1) done = 1'b1;
                n++;
            end
            tick();
        end
        n_checks++; if (n !== N || !done) $display("FAIL nodecim_count: got %0d done %b expected %0d 1", n, done, N); else n_pass++;
        for (int k = 0; k < N && k < n; k++) begin
            n_checks++;
            if (w[k] !== WS'(7 + k) || l[k] !== (k == N - 1))
                $display("FAIL nodecim_word%0d: got %0d last %b expected %0d last %b", k, w[k], l[k], 7 + k, k == N - 1);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_group_values();
        test_backpressure();
        test_drops();
        test_reset_mid();
        test_no_decim();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish before 500000");
        $fatal(1, "watchdog expired");
    end
endmodule
